// File: rtl/ising_phase_sampler.sv
// Purpose : anneal run controller and spin readout for the oscillator matrix.
// Latency : done follows start after RST_CYCLES + max(run_cycles,1) + max(window,1) cycles; rdata lags rd_addr by 1 cycle.
// Backpressure: none; a start outside IDLE is dropped, not queued.
//
// Ports:
//   i_clk, i_axi_rst      clock, synchronous active-high reset
//   i_start               1-cycle run request (accepted only in IDLE)
//   i_run_cycles/i_window settle time and sample window, captured at start
//   i_osc_ver             asynchronous oscillator outputs
//   o_ising_rstn          oscillator-array reset (active-low)
//   o_busy, o_done        run in progress / 1-cycle completion pulse
//   o_spins               latched spin result, bit 0 is the reference (always 0)
//   i_rd_addr, o_rdata    registered read port
// Build option: define MISMATCH_READBACK_EN to expose the mismatch counters at rd_addr 2+i.
module ising_phase_sampler #(
  parameter int N           = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 16
) (
  input  logic             i_clk,
  input  logic             i_axi_rst,
  input  logic             i_start,
  input  logic [31:0]      i_run_cycles,
  input  logic [CNT_W-1:0] i_window,
  input  logic [N-1:0]     i_osc_ver,
  output logic             o_ising_rstn,
  output logic             o_busy,
  output logic             o_done,
  output logic [N-1:0]     o_spins,
  input  logic [7:0]       i_rd_addr,
  output logic [31:0]      o_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_SAMPLE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_tcnt;        // cycles remaining in the current timed state
  logic [31:0]      r_run_cycles;
  logic [CNT_W-1:0] r_window;
  logic [CNT_W-1:0] r_cnt [N];
  logic [N-1:0]     r_sync [SYNC_STAGES];
  logic [N-1:0]     r_spins;
  logic             r_ising_rstn;
  logic             r_done_seen;
  logic [31:0]      r_rdata;

  logic             w_last;
  logic             w_start_acc;
  logic             w_busy;
  logic             w_done;
  logic [N-1:0]     w_s;

  assign w_s         = r_sync[SYNC_STAGES-1];
  // A loaded length of 0 or 1 both mean "this is the final cycle".
  assign w_last      = (r_tcnt <= 32'd1);
  assign w_start_acc = (r_state == S_IDLE) && i_start;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_axi_rst) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_RST;
      S_RST:    if (w_last)  w_state_nxt = S_RUN;
      S_RUN:    if (w_last)  w_state_nxt = S_SAMPLE;
      S_SAMPLE: if (w_last)  w_state_nxt = S_DONE;
      S_DONE:                w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RST, S_RUN, S_SAMPLE: w_busy = 1'b1;
      S_DONE:                 w_done = 1'b1;
      default:                ;
    endcase
  end

  // Datapath: synchroniser, timers, mismatch counters, spin latch
  always_ff @(posedge i_clk) begin
    if (i_axi_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      r_tcnt       <= '0;
      r_run_cycles <= '0;
      r_window     <= '0;
      r_spins      <= '0;
      r_ising_rstn <= 1'b0;
      r_done_seen  <= 1'b0;
    end else begin
      r_sync[0] <= i_osc_ver;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];

      case (r_state)
        S_IDLE: begin
          if (w_start_acc) begin
            r_run_cycles <= i_run_cycles;
            r_window     <= (i_window == '0) ? CNT_W'(1) : i_window;
            r_tcnt       <= 32'(RST_CYCLES);
            r_ising_rstn <= 1'b0;
            r_done_seen  <= 1'b0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
          end
        end
        S_RST: begin
          if (w_last) begin
            r_tcnt       <= r_run_cycles;
            r_ising_rstn <= 1'b1;  // array left running from here until the next start
          end else begin
            r_tcnt <= r_tcnt - 32'd1;
          end
        end
        S_RUN: begin
          if (w_last) r_tcnt <= 32'(r_window);
          else        r_tcnt <= r_tcnt - 32'd1;
        end
        S_SAMPLE: begin
          r_tcnt <= r_tcnt - 32'd1;
          for (int i = 0; i < N; i++) begin
            if ((w_s[i] ^ w_s[0]) && (r_cnt[i] != {CNT_W{1'b1}}))
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_done_seen <= 1'b1;
          // Strictly greater: an exact half-window tie reads as in-phase.
          for (int i = 1; i < N; i++) r_spins[i] <= (r_cnt[i] > (r_window >> 1));
          r_spins[0] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Registered read port
  always_ff @(posedge i_clk) begin
    if (i_axi_rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= '0;
      case (i_rd_addr)
        8'd0:    r_rdata <= 32'(r_spins);
        8'd1:    r_rdata <= {30'b0, r_done_seen, w_busy};
        default: begin
`ifdef MISMATCH_READBACK_EN
          for (int i = 0; i < N; i++) begin
            if (i_rd_addr == 8'(i + 2)) r_rdata <= 32'(r_cnt[i]);
          end
`else
          r_rdata <= '0;
`endif
        end
      endcase
    end
  end

  assign o_ising_rstn = r_ising_rstn;
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_spins      = r_spins;
  assign o_rdata      = r_rdata;

endmodule

// File: tb/tb_ising_phase_sampler.sv
// Purpose : directed self-checking bench for ising_phase_sampler.
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_ising_phase_sampler;

  logic        clk = 1'b0;
  logic        axi_rst;
  logic        start;
  logic [31:0] run_cycles;
  logic [15:0] window;
  logic [7:0]  osc_ver;
  logic        ising_rstn;
  logic        busy;
  logic        done;
  logic [7:0]  spins;
  logic [7:0]  rd_addr;
  logic [31:0] rdata;

  logic [7:0]  osc_static = 8'h00;
  logic        qmode = 1'b0;
  logic [1:0]  ph = 2'd0;
  logic [1:0]  ph1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Quarter-phase mode: osc[0] is a period-4 square wave, osc[2] leads it by one cycle.
  always @(negedge clk) ph <= ph + 2'd1;
  always_comb begin
    ph1     = ph + 2'd1;
    osc_ver = osc_static;
    if (qmode) begin
      osc_ver[0] = ph[1];
      osc_ver[2] = ph1[1];
    end
  end

  ising_phase_sampler #(.N(8), .CNT_W(16), .SYNC_STAGES(2), .RST_CYCLES(16)) dut (
    .i_clk        (clk),
    .i_axi_rst    (axi_rst),
    .i_start      (start),
    .i_run_cycles (run_cycles),
    .i_window     (window),
    .i_osc_ver    (osc_ver),
    .o_ising_rstn (ising_rstn),
    .o_busy       (busy),
    .o_done       (done),
    .o_spins      (spins),
    .i_rd_addr    (rd_addr),
    .o_rdata      (rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rdata;
  endtask

  // Issue a start and profile the run: cycles with rstn low/high while busy, done pulses seen.
  // pulse_at >= 0 fires a second start (with a different window) that many cycles in.
  task automatic run(input logic [31:0] rc, input logic [15:0] win, input int pulse_at,
                     output int n_lo, output int n_hi, output int n_done, output int timed_out);
    bit got;
    n_lo = 0; n_hi = 0; n_done = 0; got = 0;
    start = 1'b1; run_cycles = rc; window = win;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (done) begin
        n_done++;
        got = 1;
        break;
      end
      if (busy) begin
        if (ising_rstn) n_hi++;
        else            n_lo++;
      end
      if (k == pulse_at) begin
        start  = 1'b1;
        window = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    timed_out = got ? 0 : 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
  endtask

  initial begin
    int          lo, hi, nd, to, extra;
    logic [31:0] d;

    axi_rst = 1'b1; start = 1'b0; run_cycles = '0; window = '0; rd_addr = 8'd0;

    // Reset held 3 cycles; start during reset must be discarded.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_rstn",  32'(ising_rstn), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_spins", 32'(spins),      32'd0);
    chk("rst_rdata", rdata,           32'd0);
    axi_rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_dropped", 32'(busy), 32'd0);

    // In-phase run: 16 low, 5+10 high, one done, spins zero.
    run(32'd5, 16'd10, -1, lo, hi, nd, to);
    chk("t1_timeout", 32'(to), 32'd0);
    chk("t1_rst_len", 32'(lo), 32'd16);
    chk("t1_hi_len",  32'(hi), 32'd15);
    chk("t1_ndone",   32'(nd), 32'd1);
    chk("t1_spins",   32'(spins), 32'h00);
    chk("t1_rstn_hold", 32'(ising_rstn), 32'd1);
    rd(8'd1, d);
    chk("t1_status", d, 32'h2);

    // osc[3] inverted, run_cycles=0, start pulsed mid-SAMPLE with window 3.
    osc_static = 8'h08;
    run(32'd0, 16'd100, 40, lo, hi, nd, to);
    chk("t2_timeout", 32'(to), 32'd0);
    chk("t2_rst_len", 32'(lo), 32'd16);
    chk("t2_hi_len",  32'(hi), 32'd101);
    chk("t2_ndone",   32'(nd), 32'd1);
    chk("t2_spins",   32'(spins), 32'h08);
    rd(8'd0, d);
    chk("t2_rd0", d, 32'h8);
    rd(8'd5, d);
`ifdef MISMATCH_READBACK_EN
    chk("t2_rd_cnt3", d, 32'd100);
`else
    chk("t2_rd_cnt3", d, 32'd0);
`endif
    rd(8'd200, d);
    chk("t2_rd_unmapped", d, 32'd0);

    // window=0 behaves as window=1.
    run(32'd0, 16'd0, -1, lo, hi, nd, to);
    chk("t3_timeout", 32'(to), 32'd0);
    chk("t3_hi_len",  32'(hi), 32'd2);
    chk("t3_spins",   32'(spins), 32'h08);

`ifdef MISMATCH_READBACK_EN
    // Quarter-phase osc[2]: exactly half the window mismatches -> tie -> spin 0.
    osc_static = 8'h00; qmode = 1'b1;
    run(32'd0, 16'd40, -1, lo, hi, nd, to);
    chk("t4_timeout", 32'(to), 32'd0);
    chk("t4_hi_len",  32'(hi), 32'd41);
    rd(8'd4, d);
    chk("t4_rd_cnt2", d, 32'd20);
    chk("t4_spins",   32'(spins), 32'h00);
    qmode = 1'b0; osc_static = 8'h08;
    run(32'd0, 16'd4, -1, lo, hi, nd, to);
    chk("t4b_spins",  32'(spins), 32'h08);
`endif

    // Reset in the middle of RUN.
    start = 1'b1; run_cycles = 32'd50; window = 16'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_busy_run", 32'(busy),       32'd1);
    chk("t5_rstn_run", 32'(ising_rstn), 32'd1);
    rd(8'd1, d);
    chk("t5_status_busy", d, 32'h1);
    axi_rst = 1'b1;
    @(negedge clk);
    axi_rst = 1'b0;
    chk("t5_busy",  32'(busy),       32'd0);
    chk("t5_rstn",  32'(ising_rstn), 32'd0);
    chk("t5_spins", 32'(spins),      32'd0);
    chk("t5_rdata", rdata,           32'd0);
    extra = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("t5_no_done", 32'(extra), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
